// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - RV32I funct3 encodings for loads and stores
//   - controller FSM state encoding (3-bit)
//   - DMEM MemRW levels
//   - lsu_req_err(): decode-time legality check (funct3 + alignment)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Returns 1 when a request must be rejected without touching DMEM:
  // illegal funct3 for its direction, or a halfword/word access that is
  // not naturally aligned. Illegal encodings are rejected regardless of
  // their low bits, so the alignment test only matters for legal ones.
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (we)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store controller.
//   word      in  32  word read from DMEM
//   addr_lo   in   2  byte offset within the word
//   funct3    in   3  RV32I funct3 of the access
//   wdata     in  16  low half of the store data (only SB/SH merge here)
//   load_data out 32  selected lane, sign/zero extended per funct3
//   merged    out 32  word with the SB/SH data merged into its lane(s)
// Lanes are little-endian: byte n is word[8n+7:8n], halfword uses addr_lo[1].
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Each byte lane either keeps the old memory byte or takes store data.
  // For SH the upper byte of the halfword lands in the odd lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      assign hit = ((funct3 == F3_B) && (addr_lo == LANE)) ||
                   ((funct3 == F3_H) && (addr_lo[1] == LANE[1]));
      assign merged[8*gi +: 8] = !hit ? word[8*gi +: 8] :
                                 (funct3 == F3_H) ? wdata[8*(gi%2) +: 8] :
                                 wdata[7:0];
    end
  endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller in front of a word-addressed DMEM.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (accepted only in IDLE)
//   req_we, req_funct3         direction and RV32I access size/sign
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       extended load data (0 for stores/errors), error
//   mem_rw                     DMEM MemRW, 1=read, 0=write (0 only in WRITE)
//   mem_addr, mem_wdata        DMEM word index and write data
//   mem_rdata                  DMEM combinational read data
// Optional build macro LSU_RANGE_CHECK_EN: reject addr >= DEPTH*4 as an
// error without accessing DMEM. Without it, addresses pass through unmasked.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (DEPTH < 1) begin : g_depth_check
    $error("lsu_ctrl: DEPTH must be at least 1");
  end

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  // Holds the raw store data from accept; RMW_RD overwrites it with the
  // merged word, so WRITE always drives this register unchanged.
  logic [31:0] mem_wdata_reg;

  logic        range_err;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH) << 2;
  assign range_err = (req_addr >= ADDR_LIMIT);
`else
  assign range_err = 1'b0;
`endif

  assign req_err = lsu_req_err(req_we, req_funct3, req_addr[1:0]) | range_err;

  lsu_lane u_lane (
    .word      (mem_rdata),
    .addr_lo   (addr_reg[1:0]),
    .funct3    (funct3_reg),
    .wdata     (mem_wdata_reg[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Direction is carried by the state path (LOAD vs RMW_RD/WRITE), so the
  // latched request only needs address, funct3 and data.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rw     = MEM_READ;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                 state_next = ST_RESP;
          else if (!req_we)            state_next = ST_LOAD;
          else if (req_funct3 == F3_W) state_next = ST_WRITE;
          else                         state_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_next = ST_RESP;
      ST_RMW_RD: state_next = ST_WRITE;
      ST_WRITE: begin
        mem_rw     = MEM_WRITE;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      funct3_reg    <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg      <= req_addr;
            funct3_reg    <= req_funct3;
            mem_wdata_reg <= req_wdata;
            err_reg       <= req_err;
            rdata_reg     <= '0;
          end
        end
        ST_LOAD:   rdata_reg     <= load_data;
        ST_RMW_RD: mem_wdata_reg <= merged;
        ST_RESP: begin
          if (resp_ready) begin
            err_reg   <= 1'b0;
            rdata_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = {2'b00, addr_reg[31:2]};
  assign mem_wdata  = mem_wdata_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_rw;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // DMEM device: combinational read, write on every edge where MemRW=0.
  logic [31:0] dmem [64];
  int          wr_count = 0;
  logic [31:0] last_waddr, last_wdata;
  assign mem_rdata = dmem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_rw === 1'b0) begin
      dmem[mem_addr[5:0]] = mem_wdata;
      wr_count   = wr_count + 1;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  // Reference model: flat byte-addressed memory.
  logic [7:0] ref_mem [256];

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    if (!legal) return 1'b1;
    if ((a % size) != 0) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if (a >= 32'd256) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int i, v;
    i = int'(a[7:0]);
    case (f3)
      3'd0: begin v = ref_mem[i]; if (v >= 128) v -= 256; return 32'(v); end
      3'd4: return 32'(ref_mem[i]);
      3'd1: begin v = ref_mem[i] + 256 * ref_mem[i+1]; if (v >= 32768) v -= 65536; return 32'(v); end
      3'd5: return 32'(ref_mem[i] + 256 * ref_mem[i+1]);
      default: return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endcase
  endfunction

  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] d;
    n = 1 << f3[1:0];
    d = wd;
    for (int k = 0; k < n; k++) begin
      ref_mem[int'(a[7:0]) + k] = d[7:0];
      d = d >> 8;
    end
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]) & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // Observations of the most recent transaction.
  logic [31:0] o_rdata;
  logic        o_err, o_stable;
  int          o_lat, o_nwr;

  // Drives one request, measures latency (edges from accept edge inclusive
  // until resp_valid), optionally stalls the response, then completes it.
  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
    int wr0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    wr0 = wr_count;
    @(posedge clk); #1;
    // Garbage on the request bus must be ignored outside IDLE.
    req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    o_lat = 1;
    while (resp_valid !== 1'b1 && o_lat < 12) begin
      @(posedge clk); #1;
      o_lat++;
    end
    if (resp_valid !== 1'b1) o_lat = 99;
    o_rdata = resp_rdata; o_err = resp_err; o_stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== o_rdata || resp_err !== o_err || req_ready !== 1'b0)
        o_stable = 1'b0;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    o_nwr = wr_count - wr0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    checks++; if (mem_rw !== 1'b1) begin failures++; $display("FAIL reset_mem_rw got=%b want=1", mem_rw); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_directed;
    logic [2:0]  f3s [4] = '{3'd0, 3'd5, 3'd1, 3'd2};
    logic [31:0] adr [4] = '{32'h12, 32'h12, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFF99, 32'h00008899, 32'hFFFF8899, 32'h8899AABB};
    logic        ewe [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  ef3 [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ead [3] = '{32'h13, 32'h11, 32'h10};
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, f3s[i], adr[i], 32'h0, 0);
      $display("txn load f3=%0d addr=%h rdata=%h err=%b lat=%0d", f3s[i], adr[i], o_rdata, o_err, o_lat);
      checks++; if (o_rdata !== exp[i]) begin failures++; $display("FAIL dir_load_rdata[%0d] got=%h want=%h", i, o_rdata, exp[i]); end
      checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL dir_load_err[%0d] got=%b want=0", i, o_err); end
      checks++; if (o_lat != 2) begin failures++; $display("FAIL dir_load_lat[%0d] got=%0d want=2", i, o_lat); end
    end
    run_txn(1'b1, 3'd0, 32'h11, 32'h000000CC, 0);
    ref_store(3'd0, 32'h11, 32'h000000CC);
    $display("txn SB addr=11 writes=%0d wdata=%h lat=%0d", o_nwr, last_wdata, o_lat);
    checks++; if (o_nwr != 1) begin failures++; $display("FAIL dir_sb_writes got=%0d want=1", o_nwr); end
    checks++; if (last_wdata !== 32'h8899CCBB) begin failures++; $display("FAIL dir_sb_wdata got=%h want=8899ccbb", last_wdata); end
    checks++; if (last_waddr !== 32'h4) begin failures++; $display("FAIL dir_sb_waddr got=%h want=4", last_waddr); end
    checks++; if (o_lat != 3) begin failures++; $display("FAIL dir_sb_lat got=%0d want=3", o_lat); end
    checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL dir_sb_rdata got=%h want=0", o_rdata); end
    run_txn(1'b0, 3'd2, 32'h10, 32'h0, 0);
    $display("txn LW addr=10 rdata=%h", o_rdata);
    checks++; if (o_rdata !== 32'h8899CCBB) begin failures++; $display("FAIL dir_lw_after_sb got=%h want=8899ccbb", o_rdata); end
    for (int i = 0; i < 3; i++) begin
      run_txn(ewe[i], ef3[i], ead[i], 32'hFFFFFFFF, 0);
      $display("txn err we=%b f3=%0d addr=%h err=%b rdata=%h lat=%0d writes=%0d", ewe[i], ef3[i], ead[i], o_err, o_rdata, o_lat, o_nwr);
      checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL dir_err_flag[%0d] got=%b want=1", i, o_err); end
      checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL dir_err_rdata[%0d] got=%h want=0", i, o_rdata); end
      checks++; if (o_lat != 1) begin failures++; $display("FAIL dir_err_lat[%0d] got=%0d want=1", i, o_lat); end
      checks++; if (o_nwr != 0) begin failures++; $display("FAIL dir_err_writes[%0d] got=%0d want=0", i, o_nwr); end
    end
`ifdef LSU_RANGE_CHECK_EN
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 0);
    $display("txn LW addr=100 err=%b lat=%0d writes=%0d", o_err, o_lat, o_nwr);
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL dir_range_err got=%b want=1", o_err); end
    checks++; if (o_lat != 1) begin failures++; $display("FAIL dir_range_lat got=%0d want=1", o_lat); end
    run_txn(1'b1, 3'd2, 32'h104, 32'h12345678, 0);
    $display("txn SW addr=104 err=%b writes=%0d", o_err, o_nwr);
    checks++; if (o_nwr != 0) begin failures++; $display("FAIL dir_range_writes got=%0d want=0", o_nwr); end
`endif
  endtask

  task automatic test_stall;
    logic [31:0] e;
    e = ref_load(3'd2, 32'h10);
    run_txn(1'b0, 3'd2, 32'h10, 32'h0, 5);
    $display("txn stalled LW addr=10 rdata=%h stable=%b", o_rdata, o_stable);
    checks++; if (o_stable !== 1'b1) begin failures++; $display("FAIL stall_stable got=%b want=1", o_stable); end
    checks++; if (o_rdata !== e) begin failures++; $display("FAIL stall_rdata got=%h want=%h", o_rdata, e); end
  endtask

  task automatic test_reset_midop;
    int wr0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h5A;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_rw !== 1'b1) begin failures++; $display("FAIL midrst_mem_rw got=%b want=1", mem_rw); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("txn SB aborted by reset writes=%0d", wr_count - wr0);
    checks++; if (wr_count != wr0) begin failures++; $display("FAIL midrst_writes got=%0d want=%0d", wr_count, wr0); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_req_ready got=%b want=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL midrst_resp_valid got=%b want=0", resp_valid); end
  endtask

  task automatic test_random;
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rdata, e_word;
    int          e_lat, e_nwr, hold;
    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a = a & ~32'(3);
`ifdef LSU_RANGE_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(256, 1023));
`endif
      wd = $urandom;
      hold = $urandom_range(0, 2);
      e_err = ref_err(we, f3, a);
      e_rdata = (!we && !e_err) ? ref_load(f3, a) : 32'h0;
      e_lat = e_err ? 1 : (!we || f3 == 3'd2) ? 2 : 3;
      e_nwr = (we && !e_err) ? 1 : 0;
      e_word = 32'h0;
      if (we && !e_err) begin
        ref_store(f3, a, wd);
        e_word = ref_word(a);
      end
      run_txn(we, f3, a, wd, hold);
      $display("txn %0d we=%b f3=%0d addr=%h wdata=%h rdata=%h err=%b lat=%0d writes=%0d",
               t, we, f3, a, wd, o_rdata, o_err, o_lat, o_nwr);
      checks++; if (o_err !== e_err) begin failures++; $display("FAIL rnd_err[%0d] got=%b want=%b", t, o_err, e_err); end
      checks++; if (o_rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", t, o_rdata, e_rdata); end
      checks++; if (o_lat != e_lat) begin failures++; $display("FAIL rnd_lat[%0d] got=%0d want=%0d", t, o_lat, e_lat); end
      checks++; if (o_nwr != e_nwr) begin failures++; $display("FAIL rnd_writes[%0d] got=%0d want=%0d", t, o_nwr, e_nwr); end
      checks++; if (o_stable !== 1'b1) begin failures++; $display("FAIL rnd_stable[%0d] got=%b want=1", t, o_stable); end
      if (e_nwr == 1) begin
        checks++; if (last_wdata !== e_word) begin failures++; $display("FAIL rnd_wdata[%0d] got=%h want=%h", t, last_wdata, e_word); end
        checks++; if (last_waddr !== (a >> 2)) begin failures++; $display("FAIL rnd_waddr[%0d] got=%h want=%h", t, last_waddr, a >> 2); end
      end
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rnd_idle[%0d] got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1", t, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    dmem[4] = 32'h8899AABB;
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = 8'(dmem[i] >> (8*b));
    test_reset;
    test_directed;
    test_stall;
    test_reset_midop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
